// File: rtl/uart_rx.sv
// UART receive path: 16x oversampled start/data/parity/stop recovery with a
// 2-of-3 mid-bit majority vote and registered byte/status outputs.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       baud_x16_ce,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_error,
    output logic       rx_parity_error,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    localparam int         SHIFT    = 8 - DATA_BITS;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state;
    logic [3:0]             tick;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   s7, s8, par_err;
    logic                   maj, mid, last_tick;
    logic [7:0]             data_rj;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign maj       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign mid       = (tick == 4'd9);
    assign last_tick = (tick == 4'd15);
    // Data bits enter at the MSB, so the frame ends up left-justified.
    assign data_rj   = shreg >> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            tick            <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            s7              <= 1'b0;
            s8              <= 1'b0;
            par_err         <= 1'b0;
            rx_data         <= '0;
            rx_data_valid   <= 1'b0;
            rx_error        <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_busy         <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            if (baud_x16_ce) begin
                if (state != IDLE) tick <= tick + 4'd1;
                if (tick == 4'd7) s7 <= rx_s;
                if (tick == 4'd8) s8 <= rx_s;
                case (state)
                    IDLE: if (!rx_s) begin
                        state   <= START;
                        tick    <= 4'd1;
                        rx_busy <= 1'b1;
                    end
                    START: begin
                        if (mid && maj) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else if (last_tick) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (mid) shreg <= {maj, shreg[7:1]};
                        if (last_tick) begin
                            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
                            else                     bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PAR: begin
                        if (mid) par_err <= (^data_rj) ^ maj ^ (PARITY == 2);
                        if (last_tick) state <= STOP;
                    end
                    // Good stop returns to IDLE at mid-bit so the next start edge is never missed.
                    STOP: if (mid) begin
                        rx_data         <= data_rj;
                        rx_error        <= !maj;
                        rx_parity_error <= (PARITY != 0) && par_err;
                        rx_data_valid   <= 1'b1;
                        rx_busy         <= !maj;
                        state           <= maj ? IDLE : BRK;
                    end
                    BRK: if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four configurations (8N1, 8E1, 8O1, 7N1) fed directed frames,
// with a frame-level scoreboard checked every cycle.
module tb_uart_rx;
    logic clk = 1'b0, reset = 1'b1, baud_ce = 1'b0;
    logic rx_a = 1'b1, rx_p = 1'b1, rx_7 = 1'b1;
    logic [7:0] d_data [4];
    logic d_vld [4], d_err [4], d_perr [4], d_busy [4];

    typedef struct packed {logic [7:0] d; logic e; logic p;} exp_t;
    exp_t expq [4][32];
    exp_t hold [4];
    int   wr [4], rd [4];
    logic prev_vld [4];
    int   checks = 0, errors = 0;
    int   ce_div = 27, ce_cnt = 0;

    uart_rx u0 (.clk(clk), .reset(reset), .rx_i(rx_a), .baud_x16_ce(baud_ce),
        .rx_data(d_data[0]), .rx_data_valid(d_vld[0]), .rx_error(d_err[0]),
        .rx_parity_error(d_perr[0]), .rx_busy(d_busy[0]));
    uart_rx #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .rx_i(rx_p), .baud_x16_ce(baud_ce),
        .rx_data(d_data[1]), .rx_data_valid(d_vld[1]), .rx_error(d_err[1]),
        .rx_parity_error(d_perr[1]), .rx_busy(d_busy[1]));
    uart_rx #(.PARITY(2)) u2 (.clk(clk), .reset(reset), .rx_i(rx_p), .baud_x16_ce(baud_ce),
        .rx_data(d_data[2]), .rx_data_valid(d_vld[2]), .rx_error(d_err[2]),
        .rx_parity_error(d_perr[2]), .rx_busy(d_busy[2]));
    uart_rx #(.DATA_BITS(7), .SYNC_STAGES(3)) u3 (.clk(clk), .reset(reset), .rx_i(rx_7),
        .baud_x16_ce(baud_ce), .rx_data(d_data[3]), .rx_data_valid(d_vld[3]),
        .rx_error(d_err[3]), .rx_parity_error(d_perr[3]), .rx_busy(d_busy[3]));

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (ce_cnt >= ce_div - 1) begin ce_cnt = 0; baud_ce = 1'b1; end
        else begin ce_cnt++; baud_ce = 1'b0; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one frame, straight from the framing rules.
    function automatic exp_t model(input logic [7:0] data, input int nbits, input int pmode,
                                   input logic pbit, input logic stop);
        exp_t r;
        int   ones;
        r.d  = data & 8'((1 << nbits) - 1);
        ones = $countones(r.d) + int'(pbit);
        r.e  = !stop;
        r.p  = (pmode == 0) ? 1'b0 : (pmode == 1) ? (ones % 2 != 0) : (ones % 2 == 0);
        return r;
    endfunction

    task automatic push(input int i, input exp_t e);
        expq[i][wr[i]] = e;
        wr[i]++;
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_p = v;
            default: rx_7 = v;
        endcase
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_ce) @(posedge clk);
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic pbit, input logic stop);
        logic [11:0] fr;
        int n;
        fr = '0;
        n  = 1;
        for (int k = 0; k < nbits; k++) begin fr[n] = data[k]; n++; end
        if (has_par) begin fr[n] = pbit; n++; end
        fr[n] = stop;
        n++;
        for (int k = 0; k < n; k++) begin
            set_line(sel, fr[k]);
            wait_ticks(16);
            #1;
        end
    endtask

    task automatic send8(input logic [7:0] d);
        push(0, model(d, 8, 0, 1'b0, 1'b1));
        send_frame(0, d, 8, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_par(input logic [7:0] d, input logic pbit);
        push(1, model(d, 8, 1, pbit, 1'b1));
        push(2, model(d, 8, 2, pbit, 1'b1));
        send_frame(1, d, 8, 1'b1, pbit, 1'b1);
    endtask

    // Scoreboard: every strobe must match the next queued frame, and the
    // status outputs must hold the last frame's values between strobes.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (d_vld[i]) begin
                    chk($sformatf("u%0d strobe width", i), {31'd0, prev_vld[i]}, 0);
                    if (rd[i] < wr[i]) begin
                        chk($sformatf("u%0d data", i), {24'd0, d_data[i]}, {24'd0, expq[i][rd[i]].d});
                        chk($sformatf("u%0d rx_error", i), {31'd0, d_err[i]}, {31'd0, expq[i][rd[i]].e});
                        chk($sformatf("u%0d parity_error", i), {31'd0, d_perr[i]}, {31'd0, expq[i][rd[i]].p});
                        hold[i] = expq[i][rd[i]];
                        rd[i]++;
                    end else begin
                        chk($sformatf("u%0d unexpected strobe", i), {31'd0, d_vld[i]}, 0);
                    end
                end else begin
                    chk($sformatf("u%0d held status", i),
                        {22'd0, d_data[i], d_err[i], d_perr[i]}, {22'd0, hold[i]});
                end
                prev_vld[i] = d_vld[i];
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0; rd[i] = 0; hold[i] = '0; prev_vld[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d reset data", i), {24'd0, d_data[i]}, 0);
            chk($sformatf("u%0d reset flags", i), {28'd0, d_vld[i], d_err[i], d_perr[i], d_busy[i]}, 0);
        end

        // Pin the model against hand-worked frames.
        chk("model even p1", {31'd0, model(8'h07, 8, 1, 1'b1, 1'b1).p}, 0);
        chk("model even p0", {31'd0, model(8'h07, 8, 1, 1'b0, 1'b1).p}, 1);
        chk("model odd p0", {31'd0, model(8'h07, 8, 2, 1'b0, 1'b1).p}, 0);
        chk("model 7bit", {24'd0, model(8'hFF, 7, 0, 1'b0, 1'b1).d}, 8'h7F);
        chk("model bad stop", {31'd0, model(8'hA3, 8, 0, 1'b0, 1'b0).e}, 1);

        // 8N1 0x55 at ce every 27 clks, with busy edges pinned.
        wait_ticks(2);
        #1 chk("busy idle", {31'd0, d_busy[0]}, 0);
        push(0, model(8'h55, 8, 0, 1'b0, 1'b1));
        fork
            send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1);
            begin
                wait_ticks(1);
                #1 chk("busy after start", {31'd0, d_busy[0]}, 1);
                wait_ticks(152);
                #1 chk("busy stop tick 8", {31'd0, d_busy[0]}, 1);
                wait_ticks(1);
                #1 chk("busy stop tick 9", {31'd0, d_busy[0]}, 0);
            end
        join
        wait_ticks(4);
        #1 chk("strobes 0x55", rd[0], 1);
        ce_div = 8;

        // False start: 3 low ticks.
        set_line(0, 1'b0);
        wait_ticks(2);
        #1 chk("glitch busy", {31'd0, d_busy[0]}, 1);
        wait_ticks(1);
        #1 set_line(0, 1'b1);
        wait_ticks(6);
        #1 chk("glitch busy tick 8", {31'd0, d_busy[0]}, 1);
        wait_ticks(1);
        #1 chk("glitch busy tick 9", {31'd0, d_busy[0]}, 0);
        wait_ticks(16);
        #1 chk("glitch no strobe", rd[0], 1);
        send8(8'hA3);

        // Bad stop then a held-low line.
        push(0, model(8'hA3, 8, 0, 1'b0, 1'b0));
        send_frame(0, 8'hA3, 8, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        #1 chk("break busy", {31'd0, d_busy[0]}, 1);
        chk("break one strobe", rd[0], 3);
        set_line(0, 1'b1);
        wait_ticks(2);
        #1 chk("break release busy", {31'd0, d_busy[0]}, 0);
        wait_ticks(16);
        #1 send8(8'h3C);

        // Parity, even and odd receivers on one line.
        send_par(8'h07, 1'b1);
        send_par(8'h07, 1'b0);
        wait_ticks(4);
        #1 chk("parity strobes", rd[1] + rd[2], 4);

        // 0xFF with a 1-tick low glitch at tick 8 of data bit 3.
        push(0, model(8'hFF, 8, 0, 1'b0, 1'b1));
        set_line(0, 1'b0);
        wait_ticks(16);
        #1 set_line(0, 1'b1);
        wait_ticks(56);
        #1 set_line(0, 1'b0);
        wait_ticks(1);
        #1 set_line(0, 1'b1);
        wait_ticks(87);
        #1;

        // Back-to-back frames, no idle gap.
        for (int k = 0; k < 10; k++) send8(8'(k));
        wait_ticks(4);
        #1 chk("back-to-back strobes", rd[0], 15);

        // Reset pulse during data bit 4 of 0xF0.
        set_line(0, 1'b0);
        wait_ticks(80);
        #1 set_line(0, 1'b1);
        wait_ticks(4);
        #1 reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) hold[i] = '0;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post-reset outputs", {23'd0, d_data[0], d_vld[0], d_err[0], d_perr[0], d_busy[0]}, 0);
        wait_ticks(80);
        #1 chk("reset no strobe", rd[0], 15);
        send8(8'h81);

        // 7-bit receiver.
        push(3, model(8'h7F, 7, 0, 1'b0, 1'b1));
        send_frame(2, 8'h7F, 7, 1'b0, 1'b0, 1'b1);
        push(3, model(8'h35, 7, 0, 1'b0, 1'b1));
        send_frame(2, 8'h35, 7, 1'b0, 1'b0, 1'b1);

        wait_ticks(20);
        #1;
        chk("u0 total strobes", rd[0], 16);
        chk("u1 total strobes", rd[1], 2);
        chk("u2 total strobes", rd[2], 2);
        chk("u3 total strobes", rd[3], 2);
        for (int i = 0; i < 4; i++) chk($sformatf("u%0d pending frames", i), rd[i], wr[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
